// File: rtl/pcie_app_pkg.sv
// Shared register map and types for the pcie-dma app blocks.
package pcie_app_pkg;

    localparam int CONSUMER_RATE_WIDTH = 8;

    localparam int CONSUMER_RATE = 253;
    localparam int CHECKSUM_LSW  = 254;
    localparam int CHECKSUM_MSW  = 255;

    typedef logic [63:0] checksum_t;

    typedef enum logic {
        THR_READY = 1'b0,
        THR_GAP   = 1'b1
    } throttle_state_t;

endpackage

// File: rtl/pcie_rate_throttle.sv
// Stream throttle: after each accepted word, holds ready low for exactly `rate` cycles.
//   state     | meaning
//   THR_READY | ready asserted, waiting for a handshake
//   THR_GAP   | ready deasserted, counting down the idle gap
module pcie_rate_throttle import pcie_app_pkg::*; #(
    parameter int RATE_WIDTH = CONSUMER_RATE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic                  valid,
    output logic                  ready
);

    throttle_state_t       state_q, state_d;
    logic [RATE_WIDTH-1:0] gap_q, gap_d;
    logic                  ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= THR_READY;
            gap_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        ready_d = ready_q;
        unique case (state_q)
            THR_READY: begin
                // ready_q is low only in the first cycle out of reset
                ready_d = 1'b1;
                if (valid && ready_q && (rate != '0)) begin
                    gap_d   = rate;
                    state_d = THR_GAP;
                    ready_d = 1'b0;
                end
            end
            THR_GAP: begin
                gap_d = gap_q - RATE_WIDTH'(1);
                if (gap_q == RATE_WIDTH'(1)) begin
                    state_d = THR_READY;
                    ready_d = 1'b1;
                end
            end
        endcase
    end

    assign ready = ready_q;

endmodule

// File: rtl/pcie_dma_consumer.sv
// Throttled DMA sink: accumulates a 64-bit modular checksum and word count,
// exposing rate and checksum through the app register port.
module pcie_dma_consumer import pcie_app_pkg::*; #(
    parameter int RATE_WIDTH     = CONSUMER_RATE_WIDTH,
    parameter int REG_ADDR_WIDTH = 8
) (
    input  logic                      pcieClk_in,
    input  logic                      reset_in,
    input  logic [63:0]               rxData_in,
    input  logic                      rxValid_in,
    output logic                      rxReady_out,
    input  logic                      regWrValid_in,
    input  logic [REG_ADDR_WIDTH-1:0] regWrAddr_in,
    input  logic [31:0]               regWrData_in,
    input  logic                      regRdValid_in,
    input  logic [REG_ADDR_WIDTH-1:0] regRdAddr_in,
    output logic [31:0]               regRdData_out,
    output logic                      regRdHit_out,
    output logic [31:0]               wordCount_out
);

    logic [RATE_WIDTH-1:0] rate_q;
    checksum_t             checksum_q;
    checksum_t             sum_base;
    logic [31:0]           shadow_q;
    logic [31:0]           word_count_q;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_hit_q;
    logic                  handshake;
    logic                  wr_rate, wr_clear;
    logic                  rd_rate, rd_lsw, rd_msw;
    logic                  wr_data_unused;

    assign wr_data_unused = ^regWrData_in[31:RATE_WIDTH];

    pcie_rate_throttle #(.RATE_WIDTH(RATE_WIDTH)) u_throttle (
        .clk   (pcieClk_in),
        .reset (reset_in),
        .rate  (rate_q),
        .valid (rxValid_in),
        .ready (rxReady_out)
    );

    assign handshake = rxValid_in && rxReady_out;

    assign wr_rate  = regWrValid_in && (regWrAddr_in == REG_ADDR_WIDTH'(CONSUMER_RATE));
    assign wr_clear = regWrValid_in && ((regWrAddr_in == REG_ADDR_WIDTH'(CHECKSUM_LSW)) ||
                                        (regWrAddr_in == REG_ADDR_WIDTH'(CHECKSUM_MSW)));
    assign rd_rate  = regRdValid_in && (regRdAddr_in == REG_ADDR_WIDTH'(CONSUMER_RATE));
    assign rd_lsw   = regRdValid_in && (regRdAddr_in == REG_ADDR_WIDTH'(CHECKSUM_LSW));
    assign rd_msw   = regRdValid_in && (regRdAddr_in == REG_ADDR_WIDTH'(CHECKSUM_MSW));

    // Clear wins over the old sum; a word arriving in the same cycle still counts.
    assign sum_base = wr_clear ? '0 : checksum_q;

    always_comb begin
        rd_data_d = '0;
        if (rd_rate)     rd_data_d = 32'(rate_q);
        else if (rd_lsw) rd_data_d = checksum_q[31:0];
        else if (rd_msw) rd_data_d = shadow_q;
    end

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            rate_q       <= '0;
            checksum_q   <= '0;
            shadow_q     <= '0;
            word_count_q <= '0;
            rd_data_q    <= '0;
            rd_hit_q     <= 1'b0;
        end else begin
            if (wr_rate) rate_q <= regWrData_in[RATE_WIDTH-1:0];

            if (handshake) begin
                checksum_q   <= sum_base + rxData_in;
                word_count_q <= (wr_clear ? 32'd0 : word_count_q) + 32'd1;
            end else if (wr_clear) begin
                checksum_q   <= '0;
                word_count_q <= '0;
            end

            // An LSW read keeps the MSW coherent with the value it just returned.
            if (rd_lsw)        shadow_q <= checksum_q[63:32];
            else if (wr_clear) shadow_q <= '0;

            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_rate || rd_lsw || rd_msw;
        end
    end

    assign regRdData_out = rd_data_q;
    assign regRdHit_out  = rd_hit_q;
    assign wordCount_out = word_count_q;

endmodule

// File: tb/tb_pcie_dma_consumer.sv
// Self-checking bench for pcie_dma_consumer: read scoreboard plus acceptance-timing checks.
module tb_pcie_dma_consumer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rd_pending = 1'b0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        hit;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      acc_q[$];

    always #5 clk = ~clk;

    pcie_dma_consumer dut (
        .pcieClk_in    (clk),
        .reset_in      (reset),
        .rxData_in     (rx_data),
        .rxValid_in    (rx_valid),
        .rxReady_out   (rx_ready),
        .regWrValid_in (wr_valid),
        .regWrAddr_in  (wr_addr),
        .regWrData_in  (wr_data),
        .regRdValid_in (rd_valid),
        .regRdAddr_in  (rd_addr),
        .regRdData_out (rd_data),
        .regRdHit_out  (rd_hit),
        .wordCount_out (word_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rd_pending <= rd_valid && !reset;
    end

    always @(negedge clk) begin
        if (rx_valid && rx_ready && !reset) acc_q.push_back(cyc);
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_size", 64'(rd_q.size()), 64'd1);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk($sformatf("rd%0d_data", e.addr), 64'(rd_data), 64'(e.data));
                chk($sformatf("rd%0d_hit", e.addr), 64'(rd_hit), 64'(e.hit));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp_data, input logic exp_hit);
        rd_exp_t e;
        e.addr = int'(addr);
        e.data = exp_data;
        e.hit  = exp_hit;
        rd_q.push_back(e);
        rd_valid = 1'b1;
        rd_addr  = addr;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] data);
        int n = 0;
        rx_data  = data;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("send_wait_ready", 64'(rx_ready), 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic spacing(input string tag, input int n_exp, input int gap);
        chk({tag, "_count"}, 64'(acc_q.size()), 64'(n_exp));
        for (int i = 1; i < acc_q.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), 64'(acc_q[i] - acc_q[i-1]), 64'(gap));
    endtask

    initial begin
        tick();
        tick();
        chk("reset_ready", 64'(rx_ready), 64'd0);
        chk("reset_count", 64'(word_count), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_rd_hit", 64'(rd_hit), 64'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 64'(rx_ready), 64'd1);

        // back-to-back at rate 0
        acc_q.delete();
        for (int i = 1; i <= 4; i++) send(64'(i));
        spacing("b2b", 4, 1);
        chk("count_b2b", 64'(word_count), 64'd4);
        rd(8'd254, 32'd10, 1'b1);
        rd(8'd255, 32'd0, 1'b1);

        // rate 3: four cycles between acceptances
        wr(8'd253, 32'h0000_0103);
        acc_q.delete();
        send(64'd10);
        send(64'd20);
        send(64'd30);
        send(64'd40);
        spacing("rate3", 4, 4);
        rd(8'd253, 32'd3, 1'b1);
        rd(8'd254, 32'd110, 1'b1);
        chk("count_rate3", 64'(word_count), 64'd8);

        // 64-bit wrap
        wr(8'd254, 32'hDEAD_BEEF);
        send(64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h2);
        rd(8'd254, 32'h0000_0001, 1'b1);
        rd(8'd255, 32'h0000_0000, 1'b1);
        chk("count_wrap", 64'(word_count), 64'd2);

        // shadow coherence
        wr(8'd253, 32'd0);
        wr(8'd255, 32'd0);
        send(64'h0000_0001_FFFF_FFFF);
        rd(8'd254, 32'hFFFF_FFFF, 1'b1);
        send(64'h1);
        rd(8'd255, 32'h0000_0001, 1'b1);
        rd(8'd254, 32'h0000_0000, 1'b1);
        rd(8'd255, 32'h0000_0002, 1'b1);

        // clear coincident with a handshake
        wr_valid = 1'b1;
        wr_addr  = 8'd254;
        wr_data  = 32'd0;
        rx_data  = 64'h55;
        rx_valid = 1'b1;
        chk("ready_before_clear", 64'(rx_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        rx_valid = 1'b0;
        chk("count_clear_hs", 64'(word_count), 64'd1);
        rd(8'd254, 32'h55, 1'b1);
        rd(8'd255, 32'h0, 1'b1);

        // rate change during an active gap
        wr(8'd253, 32'd3);
        acc_q.delete();
        send(64'd1);
        wr(8'd253, 32'd5);
        send(64'd2);
        send(64'd3);
        chk("gapchg_count", 64'(acc_q.size()), 64'd3);
        if (acc_q.size() == 3) begin
            chk("gapchg_old_gap", 64'(acc_q[1] - acc_q[0]), 64'd4);
            chk("gapchg_new_gap", 64'(acc_q[2] - acc_q[1]), 64'd6);
        end
        chk("count_gapchg", 64'(word_count), 64'd4);
        rd(8'd254, 32'h5B, 1'b1);

        // reset mid-gap
        reset = 1'b1;
        tick();
        chk("midreset_ready", 64'(rx_ready), 64'd0);
        chk("midreset_count", 64'(word_count), 64'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_midreset", 64'(rx_ready), 64'd1);
        rd(8'd254, 32'd0, 1'b1);
        rd(8'd255, 32'd0, 1'b1);
        rd(8'd253, 32'd0, 1'b1);
        rd(8'd100, 32'd0, 1'b0);
        tick();
        tick();
        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
